// File: rtl/port_out_bank.sv
// Bank of memory-mapped output ports with registered readback, per-port update
// strobes and a self-clearing pulse alias backed by per-port down-counters.

module port_out_lane #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int PULSE_LEN = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_norm,
  input  logic              wr_pulse,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] port,
  output logic [CNT_W-1:0]  cnt,
  output logic              pulse_active,
  output logic              updated
);

  // Writes from either slot win over a coinciding expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port    <= '0;
      cnt     <= '0;
      updated <= 1'b0;
    end else begin
      updated <= 1'b0;
      if (wr_norm) begin
        port    <= data_in;
        cnt     <= '0;
        updated <= 1'b1;
      end else if (wr_pulse) begin
        port    <= data_in;
        cnt     <= CNT_W'(PULSE_LEN);
        updated <= 1'b1;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          port    <= '0;
          updated <= 1'b1;
        end
      end
    end
  end

  assign pulse_active = (cnt != '0);

endmodule

module port_out_bank #(
  parameter int                N_PORTS   = 16,
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hE0,
  parameter int                PULSE_LEN = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        write,
  input  logic                        read,
  output logic [DATA_W-1:0]           read_data,
  output logic                        read_valid,
  output logic [N_PORTS*DATA_W-1:0]   port_out,
  output logic [N_PORTS-1:0]          port_updated,
  output logic [N_PORTS-1:0]          pulse_active
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);

  logic [ADDR_W-1:0]                offset;
  logic [N_PORTS-1:0][DATA_W-1:0]   ports;
  logic [N_PORTS-1:0][CNT_W-1:0]    cnts;
  logic                             rd_hit;
  logic [DATA_W-1:0]                rd_val;

  // The window never wraps, so an address below BASE_ADDR wraps to an offset
  // of at least 2*N_PORTS and matches no slot.
  assign offset = address - BASE_ADDR;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_lane
    port_out_lane #(
      .DATA_W    (DATA_W),
      .CNT_W     (CNT_W),
      .PULSE_LEN (PULSE_LEN)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .wr_norm      (write && (offset == ADDR_W'(i))),
      .wr_pulse     (write && (offset == ADDR_W'(i + N_PORTS))),
      .data_in      (data_in),
      .port         (ports[i]),
      .cnt          (cnts[i]),
      .pulse_active (pulse_active[i]),
      .updated      (port_updated[i])
    );
  end

  assign port_out = ports;

  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (offset == ADDR_W'(i)) begin
        rd_hit = 1'b1;
        rd_val = ports[i];
      end
      if (offset == ADDR_W'(i + N_PORTS)) begin
        rd_hit = 1'b1;
        rd_val = DATA_W'(cnts[i]);
      end
    end
  end

  // Readback samples pre-edge state, so read-during-write returns the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read && rd_hit;
      if (read && rd_hit) read_data <= rd_val;
    end
  end

endmodule
